// File: rtl/stone_renderer.sv
// Walks stone RAM entries 0..quantity-1 each frame tick and rasterises visible stones as SPRITE^2 squares, one pixel/cycle.
// Per entry: 4 cycles if skipped, 4+SPRITE^2 if drawn; STONE_ERASE_EN also draws invisible entries in BG_COLOUR.
module stone_renderer #(
  parameter int         SPRITE    = 16,
  parameter int         SCREEN_W  = 320,
  parameter int         SCREEN_H  = 240,
  parameter logic [2:0] C_STONE   = 3'b111,
  parameter logic [2:0] C_GOLD    = 3'b110,
  parameter logic [2:0] C_DIAMOND = 3'b011,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  quantity,
  input  logic [31:0] data,
  output logic        draw_stone_flag,
  output logic [3:0]  draw_index,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);
  localparam int PW = $clog2(SPRITE);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW-1:0] P_MAX = PW'(SPRITE - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_LATCH, S_DRAW, S_NEXT, S_FIN} state_t;

  state_t        r_state;
  logic [3:0]    r_qty;
  logic [3:0]    r_index;
  logic [8:0]    r_ex;
  logic [7:0]    r_ey;
  logic [PW-1:0] r_px;
  logic [PW-1:0] r_py;
  logic          r_flag;
  logic          r_busy;
  logic          r_done;
  logic          r_plot;
  logic [8:0]    r_x;
  logic [7:0]    r_y;
  logic [2:0]    r_colour;

  function automatic logic [2:0] type_colour(input logic [1:0] t);
    case (t)
      2'b00:   type_colour = C_STONE;
      2'b01:   type_colour = C_GOLD;
      default: type_colour = C_DIAMOND;
    endcase
  endfunction

  logic       w_latch;
  logic       w_draw_entry;
  logic [2:0] w_col;
  assign w_latch = (r_state == S_LATCH);

`ifdef STONE_ERASE_EN
  assign w_draw_entry = 1'b1;
  assign w_col        = data[1] ? type_colour(data[3:2]) : BG_COLOUR;
`else
  assign w_draw_entry = data[1];
  assign w_col        = type_colour(data[3:2]);
`endif

  // Next pixel offset: origin when entering DRAW, raster-scan successor otherwise.
  logic [PW-1:0] w_npx;
  logic [PW-1:0] w_npy;
  always_comb begin
    w_npx = '0;
    w_npy = '0;
    if (!w_latch) begin
      w_npx = r_px + P_ONE;
      w_npy = (r_px == P_MAX) ? r_py + P_ONE : r_py;
    end
  end

  logic [8:0] w_bx;
  logic [7:0] w_by;
  logic [9:0] w_sx;
  logic [9:0] w_sy;
  logic       w_on;
  logic       w_last;
  assign w_bx   = w_latch ? data[31:23] : r_ex;
  assign w_by   = w_latch ? data[18:11] : r_ey;
  assign w_sx   = {1'b0, w_bx} + 10'(w_npx);
  assign w_sy   = {2'b0, w_by} + 10'(w_npy);
  assign w_on   = (w_sx < 10'(SCREEN_W)) && (w_sy < 10'(SCREEN_H));
  assign w_last = (r_px == P_MAX) && (r_py == P_MAX);

  logic w_unused;
  assign w_unused = ^{data[22:19], data[10:4], data[0]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_qty    <= '0;
      r_index  <= '0;
      r_ex     <= '0;
      r_ey     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_flag   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_plot   <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy  <= 1'b1;
            r_flag  <= 1'b1;
            r_qty   <= quantity;
            r_index <= '0;
            if (quantity == 4'd0) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_state <= S_ADDR;
            end
          end
        end
        S_ADDR: r_state <= S_WAIT;
        S_WAIT: r_state <= S_LATCH;
        S_LATCH: begin
          r_ex <= data[31:23];
          r_ey <= data[18:11];
          if (w_draw_entry) begin
            r_px     <= '0;
            r_py     <= '0;
            r_x      <= w_sx[8:0];
            r_y      <= w_sy[7:0];
            r_plot   <= w_on;
            r_colour <= w_col;
            r_state  <= S_DRAW;
          end else begin
            r_state <= S_NEXT;
          end
        end
        S_DRAW: begin
          if (w_last) begin
            r_plot  <= 1'b0;
            r_state <= S_NEXT;
          end else begin
            r_px   <= w_npx;
            r_py   <= w_npy;
            r_x    <= w_sx[8:0];
            r_y    <= w_sy[7:0];
            r_plot <= w_on;
          end
        end
        S_NEXT: begin
          if (r_index == r_qty - 4'd1) begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_index <= r_index + 4'd1;
            r_state <= S_ADDR;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_flag  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign draw_stone_flag = r_flag;
  assign draw_index      = r_index;
  assign x               = r_x;
  assign y               = r_y;
  assign colour          = r_colour;
  assign plot            = r_plot;
  assign busy            = r_busy;
  assign done            = r_done;
endmodule

// File: tb/tb_stone_renderer.sv
// Directed bench for stone_renderer: expected pixels are queued per pass and popped on every plot strobe.
module tb_stone_renderer;
  logic        clock  = 1'b0;
  logic        resetn = 1'b1;
  logic        start  = 1'b0;
  logic [3:0]  quantity = 4'd0;
  logic [31:0] data;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

`ifdef STONE_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif

  stone_renderer dut (
    .clock(clock), .resetn(resetn), .start(start), .quantity(quantity), .data(data),
    .draw_stone_flag(draw_stone_flag), .draw_index(draw_index), .x(x), .y(y),
    .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  logic [31:0] mem [16];
  assign data = mem[draw_index];

  always #5 clock = ~clock;

  typedef struct packed { logic [8:0] px; logic [7:0] py; logic [2:0] c; } pix_t;
  pix_t sb[$];
  pix_t mon_p;

  int n_assert = 0, n_fail = 0;
  int plot_cnt = 0, flag_cnt = 0, done_cnt = 0, exp_plots = 0, exp_k = 0;
  int nclk = 0, nstart = 0;

  always @(posedge clock) nclk <= nclk + 1;

  task automatic chk(input string tag, input int got, input int expv);
    n_assert++;
    assert (got === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  always @(negedge clock) begin
    if (draw_stone_flag) flag_cnt++;
    if (done) done_cnt++;
    if (plot) begin
      plot_cnt++;
      if (sb.size() == 0) begin
        chk("plot beyond scoreboard", plot_cnt, exp_plots);
      end else begin
        mon_p = sb.pop_front();
        chk("pixel x", int'(x), int'(mon_p.px));
        chk("pixel y", int'(y), int'(mon_p.py));
        chk("pixel colour", int'(colour), int'(mon_p.c));
      end
    end
  end

  function automatic logic [31:0] mk(input int ex, input int ey, input logic [1:0] t, input logic v, input logic m);
    logic [8:0] xx;
    logic [7:0] yy;
    xx = 9'(ex);
    yy = 8'(ey);
    return {xx, 4'b0, yy, 7'b0, t, v, m};
  endfunction

  function automatic logic [2:0] exp_colour(input logic [1:0] t, input logic v);
    if (!v) return 3'b000;
    case (t)
      2'b00:   return 3'b111;
      2'b01:   return 3'b110;
      default: return 3'b011;
    endcase
  endfunction

  // Queue the on-screen pixels of one entry; returns that entry's cycle cost.
  task automatic push_stone(input int idx, output int cost);
    logic [31:0] e;
    int bx, by;
    pix_t p;
    e = mem[idx];
    bx = int'(e[31:23]);
    by = int'(e[18:11]);
    cost = 4;
    if (e[1] || ERASE) begin
      cost = 4 + 256;
      for (int py = 0; py < 16; py++) begin
        for (int px = 0; px < 16; px++) begin
          if ((bx + px) < 320 && (by + py) < 240) begin
            p.px = 9'(bx + px);
            p.py = 8'(by + py);
            p.c  = exp_colour(e[3:2], e[1]);
            sb.push_back(p);
            exp_plots++;
          end
        end
      end
    end
  endtask

  task automatic start_pass(input int q);
    int cost;
    plot_cnt = 0; flag_cnt = 0; done_cnt = 0; exp_plots = 0;
    sb.delete();
    exp_k = 2;
    for (int i = 0; i < q; i++) begin
      push_stone(i, cost);
      exp_k += cost;
    end
    @(negedge clock);
    start = 1'b1;
    quantity = 4'(q);
    nstart = nclk;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic finish_pass(input string tag);
    int g;
    g = 0;
    while (done !== 1'b1 && g < 3000) begin
      @(negedge clock);
      g++;
    end
    chk({tag, " done cycle"}, nclk - nstart + 1, exp_k);
    @(negedge clock);
    #1;
    chk({tag, " done cleared"}, int'(done), 0);
    chk({tag, " busy cleared"}, int'(busy), 0);
    chk({tag, " flag cleared"}, int'(draw_stone_flag), 0);
    chk({tag, " done pulses"}, done_cnt, 1);
    chk({tag, " flag cycles"}, flag_cnt, exp_k - 1);
    chk({tag, " plot count"}, plot_cnt, exp_plots);
    chk({tag, " scoreboard drained"}, sb.size(), 0);
  endtask

  initial begin
    int g;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #1 resetn = 1'b0;
    #2;
    chk("reset plot", int'(plot), 0);
    chk("reset flag", int'(draw_stone_flag), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset x", int'(x), 0);
    chk("reset y", int'(y), 0);
    chk("reset colour", int'(colour), 0);
    chk("reset index", int'(draw_index), 0);
    @(negedge clock);
    resetn = 1'b1;

    // three visible stones, including a carried one
    mem[0] = mk(100, 50, 2'b01, 1'b1, 1'b0);
    mem[1] = mk(200, 100, 2'b00, 1'b1, 1'b1);
    mem[2] = mk(0, 0, 2'b10, 1'b1, 1'b0);
    start_pass(3);
    finish_pass("three visible");

    // clipped at bottom-right corner
    mem[0] = mk(310, 230, 2'b00, 1'b1, 1'b0);
    start_pass(1);
    finish_pass("corner clip");
    chk("corner clip pixels", exp_plots, 100);

    // invisible entry followed by a visible one
    mem[0] = mk(50, 60, 2'b11, 1'b0, 1'b0);
    mem[1] = mk(20, 20, 2'b11, 1'b1, 1'b0);
    start_pass(2);
    repeat (3) @(negedge clock);
    chk("invisible index held", int'(draw_index), 0);
    @(negedge clock);
    chk("invisible next index", int'(draw_index), ERASE ? 0 : 1);
    finish_pass("invisible entry");

    start_pass(0);
    finish_pass("empty pass");

    // async reset at the 40th pixel, then restart from index 0
    mem[0] = mk(10, 10, 2'b01, 1'b1, 1'b0);
    mem[1] = mk(300, 5, 2'b10, 1'b1, 1'b0);
    start_pass(1);
    g = 0;
    while (plot_cnt < 40 && g < 1000) begin
      @(negedge clock);
      #1;
      g++;
    end
    chk("reached pixel 40", plot_cnt, 40);
    resetn = 1'b0;
    #1;
    chk("mid-draw reset plot", int'(plot), 0);
    chk("mid-draw reset flag", int'(draw_stone_flag), 0);
    chk("mid-draw reset busy", int'(busy), 0);
    sb.delete();
    @(negedge clock);
    resetn = 1'b1;
    start_pass(2);
    chk("restart index", int'(draw_index), 0);
    chk("restart busy", int'(busy), 1);
    finish_pass("restart");

    // a second start and a new quantity mid-pass must be ignored
    mem[2] = mk(40, 40, 2'b00, 1'b1, 1'b0);
    mem[3] = mk(60, 40, 2'b00, 1'b1, 1'b0);
    mem[4] = mk(80, 40, 2'b00, 1'b1, 1'b0);
    start_pass(2);
    repeat (100) @(negedge clock);
    start = 1'b1;
    quantity = 4'd5;
    @(negedge clock);
    start = 1'b0;
    finish_pass("start while busy");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
